// File: rtl/serial_adder_nb_if.sv
// Purpose : operand/result bundle for serial_adder_nb (start, operands, mode, status, result).
// Latency : n/a (wires only).
// Backpressure: none; the adder ignores start while busy is high.
// Ports   : master drives start/a/b/cin/sub and observes busy/done/sum/cout/overflow;
//           slave is the adder side.
interface serial_adder_nb_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_nb.sv
// Purpose : digit-serial add/subtract, LSB first, DIGIT bits per clock through a ripple slice.
// Latency : WIDTH/DIGIT RUN cycles; done pulses WIDTH/DIGIT+1 edges after the accepted start.
// Backpressure: start is taken only when not busy (IDLE or DONE); starts during RUN are dropped.
// Ports   : clk, rst_n (synchronous, active low), bus (serial_adder_nb_if.slave):
//           start/a/b/cin/sub in; busy/done level status; sum/cout/overflow hold the last result.
module serial_adder_nb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_nb_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_nb: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             last_digit;
    logic             busy_c;
    logic             done_c;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;      // already inverted for subtract
    logic             carry;     // carry registered between digits
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_sh;    // partial result, filled from the top
    logic [WIDTH-1:0] res_next;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] slice_sum;
    logic [DIGIT:0]   chain;     // chain[i] = carry into slice bit i

    assign accept     = bus.start && (state != RUN);
    assign last_digit = (state == RUN) && (cnt == CNT_W'(STEPS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_digit) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // DIGIT-bit ripple slice on the low bits of the shifting operands
    always_comb begin
        chain     = '0;
        slice_sum = '0;
        chain[0]  = carry;
        for (int i = 0; i < DIGIT; i++) begin
            slice_sum[i] = a_sh[i] ^ b_sh[i] ^ chain[i];
            chain[i+1]   = (a_sh[i] & b_sh[i]) | (chain[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    // New digit enters at the top; after STEPS shifts the word is aligned.
    assign res_next = WIDTH'({slice_sum, res_sh} >> DIGIT);

    // Datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            res_sh <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + ~borrow_in, so invert B and the carry seed here.
            a_sh   <= bus.a;
            b_sh   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.cin ^ bus.sub;
            cnt    <= '0;
            res_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            carry  <= chain[DIGIT];
            cnt    <= cnt + CNT_W'(1);
            res_sh <= res_next;
            if (last_digit) begin
                // Only the final digit updates the visible result.
                sum_q  <= res_next;
                cout_q <= chain[DIGIT];
                ovf_q  <= chain[DIGIT] ^ chain[DIGIT-1];
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_nb.sv
// Purpose : directed and exhaustive checks of serial_adder_nb (W8 D1/D2, W4 D1/D2/D4).
// Latency : n/a.
// Backpressure: n/a.
module tb_serial_adder_nb;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder_nb_if #(.WIDTH(8)) i8a ();
    serial_adder_nb_if #(.WIDTH(8)) i8b ();
    serial_adder_nb_if #(.WIDTH(4)) i4a ();
    serial_adder_nb_if #(.WIDTH(4)) i4b ();
    serial_adder_nb_if #(.WIDTH(4)) i4c ();

    serial_adder_nb #(.WIDTH(8), .DIGIT(1)) u_w8d1 (.clk(clk), .rst_n(rst_n), .bus(i8a));
    serial_adder_nb #(.WIDTH(8), .DIGIT(2)) u_w8d2 (.clk(clk), .rst_n(rst_n), .bus(i8b));
    serial_adder_nb #(.WIDTH(4), .DIGIT(1)) u_w4d1 (.clk(clk), .rst_n(rst_n), .bus(i4a));
    serial_adder_nb #(.WIDTH(4), .DIGIT(2)) u_w4d2 (.clk(clk), .rst_n(rst_n), .bus(i4b));
    serial_adder_nb #(.WIDTH(4), .DIGIT(4)) u_w4d4 (.clk(clk), .rst_n(rst_n), .bus(i4c));

    // Waits on negedges for done of i8a (sel 0) or i8b (sel 1); edges = -1 on timeout.
    task automatic wait_done(input int sel, input int limit, output int edges, output int busy_cnt);
        int k = 0;
        edges    = -1;
        busy_cnt = 0;
        while (edges < 0 && k < limit) begin
            k++;
            @(negedge clk);
            if ((sel == 0 && i8a.busy === 1'b1) || (sel == 1 && i8b.busy === 1'b1)) busy_cnt++;
            if ((sel == 0 && i8a.done === 1'b1) || (sel == 1 && i8b.done === 1'b1)) edges = k;
        end
    endtask

    task automatic test_reset();
        int e, bc;
        rst_n = 1'b0;
        i8a.start = 1'b1; i8a.a = 8'h03; i8a.b = 8'h04; i8a.cin = 1'b0; i8a.sub = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (i8a.busy !== 1'b0 || i8a.done !== 1'b0 || i8a.sum !== 8'h00 || i8a.cout !== 1'b0 || i8a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_d1: busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
                     i8a.busy, i8a.done, i8a.sum, i8a.cout, i8a.overflow);
        end
        total++;
        if (i8b.busy !== 1'b0 || i8b.done !== 1'b0 || i8b.sum !== 8'h00 || i8b.cout !== 1'b0 || i8b.overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_state_d2: busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
                     i8b.busy, i8b.done, i8b.sum, i8b.cout, i8b.overflow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (i8a.busy !== 1'b1) begin
            bad++;
            $display("FAIL first_start_after_reset: busy=%b, want 1", i8a.busy);
        end
        i8a.start = 1'b0;
        wait_done(0, 12, e, bc);
        total++;
        if (e !== 8 || i8a.sum !== 8'h07) begin
            bad++;
            $display("FAIL reset_then_add: edges=%0d sum=%h, want edges=8 sum=07", e, i8a.sum);
        end
    endtask

    task automatic test_digit1_add();
        int e, bc;
        @(negedge clk);
        i8a.a = 8'h7F; i8a.b = 8'h01; i8a.cin = 1'b0; i8a.sub = 1'b0; i8a.start = 1'b1;
        @(negedge clk);
        i8a.start = 1'b0;
        total++;
        if (i8a.busy !== 1'b1 || i8a.done !== 1'b0 || i8a.sum !== 8'h07) begin
            bad++;
            $display("FAIL d1_run_hides_partial: busy=%b done=%b sum=%h, want 1 0 07", i8a.busy, i8a.done, i8a.sum);
        end
        wait_done(0, 12, e, bc);
        total++;
        if (e !== 8 || bc + 1 !== 8) begin
            bad++;
            $display("FAIL d1_latency: done_edge=%0d busy_cycles=%0d, want 9 and 8", e + 1, bc + 1);
        end
        total++;
        if (i8a.sum !== 8'h80 || i8a.cout !== 1'b0 || i8a.overflow !== 1'b1) begin
            bad++;
            $display("FAIL d1_add_7f_01: sum=%h cout=%b ovf=%b, want 80 0 1", i8a.sum, i8a.cout, i8a.overflow);
        end
        @(negedge clk);
        total++;
        if (i8a.done !== 1'b0 || i8a.busy !== 1'b0 || i8a.sum !== 8'h80) begin
            bad++;
            $display("FAIL d1_done_pulse_hold: done=%b busy=%b sum=%h, want 0 0 80", i8a.done, i8a.busy, i8a.sum);
        end
    endtask

    task automatic test_digit2_sub();
        int e, bc;
        @(negedge clk);
        i8b.a = 8'h05; i8b.b = 8'h07; i8b.cin = 1'b0; i8b.sub = 1'b1; i8b.start = 1'b1;
        @(negedge clk);
        i8b.start = 1'b0;
        wait_done(1, 10, e, bc);
        total++;
        if (e !== 4) begin
            bad++;
            $display("FAIL d2_latency: done_edge=%0d, want 5", e + 1);
        end
        total++;
        if (i8b.sum !== 8'hFE || i8b.cout !== 1'b0 || i8b.overflow !== 1'b0) begin
            bad++;
            $display("FAIL d2_sub_05_07: sum=%h cout=%b ovf=%b, want fe 0 0", i8b.sum, i8b.cout, i8b.overflow);
        end
        // Issue the next op in the DONE cycle
        i8b.a = 8'h80; i8b.b = 8'h01; i8b.cin = 1'b0; i8b.sub = 1'b1; i8b.start = 1'b1;
        @(negedge clk);
        i8b.start = 1'b0;
        wait_done(1, 10, e, bc);
        total++;
        if (e !== 4 || i8b.sum !== 8'h7F || i8b.cout !== 1'b1 || i8b.overflow !== 1'b1) begin
            bad++;
            $display("FAIL d2_sub_80_01: edges=%0d sum=%h cout=%b ovf=%b, want 4 7f 1 1",
                     e, i8b.sum, i8b.cout, i8b.overflow);
        end
    endtask

    task automatic test_ignore_busy();
        int e, bc;
        @(negedge clk);
        i8a.a = 8'hFF; i8a.b = 8'h00; i8a.cin = 1'b1; i8a.sub = 1'b0; i8a.start = 1'b1;
        @(negedge clk);
        i8a.a = 8'h12; i8a.b = 8'h34; i8a.cin = 1'b0; i8a.sub = 1'b1;
        repeat (3) @(negedge clk);
        i8a.start = 1'b0;
        wait_done(0, 12, e, bc);
        total++;
        if (e !== 5) begin
            bad++;
            $display("FAIL busy_start_timing: done_edge=%0d, want 9", e + 4);
        end
        total++;
        if (i8a.sum !== 8'h00 || i8a.cout !== 1'b1 || i8a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_ignored: sum=%h cout=%b ovf=%b, want 00 1 0", i8a.sum, i8a.cout, i8a.overflow);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        @(negedge clk);
        i8a.a = 8'h10; i8a.b = 8'h20; i8a.cin = 1'b0; i8a.sub = 1'b0; i8a.start = 1'b1;
        wait_done(0, 12, e, bc);
        total++;
        if (e !== 9 || i8a.sum !== 8'h30) begin
            bad++;
            $display("FAIL b2b_first: edges=%0d sum=%h, want 9 30", e, i8a.sum);
        end
        i8a.a = 8'h01; i8a.b = 8'h01;
        @(negedge clk);
        total++;
        if (i8a.busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_no_idle: busy=%b, want 1", i8a.busy);
        end
        i8a.start = 1'b0;
        wait_done(0, 12, e, bc);
        total++;
        if (e + 1 !== 9 || i8a.sum !== 8'h02) begin
            bad++;
            $display("FAIL b2b_second: done_gap=%0d sum=%h, want 9 02", e + 1, i8a.sum);
        end
    endtask

    task automatic test_reset_mid_run();
        int e, bc;
        @(negedge clk);
        i8a.a = 8'h55; i8a.b = 8'h22; i8a.cin = 1'b0; i8a.sub = 1'b0; i8a.start = 1'b1;
        @(negedge clk);
        i8a.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (i8a.busy !== 1'b0 || i8a.done !== 1'b0 || i8a.sum !== 8'h00 || i8a.cout !== 1'b0 || i8a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all zero",
                     i8a.busy, i8a.done, i8a.sum, i8a.cout, i8a.overflow);
        end
        wait_done(0, 12, e, bc);
        total++;
        if (e !== -1) begin
            bad++;
            $display("FAIL midrun_no_done: done seen at edge %0d, want none", e);
        end
        i8a.start = 1'b1;
        wait_done(0, 12, e, bc);
        i8a.start = 1'b0;
        total++;
        if (e !== 9 || i8a.sum !== 8'h77 || i8a.cout !== 1'b0 || i8a.overflow !== 1'b0) begin
            bad++;
            $display("FAIL midrun_restart: edges=%0d sum=%h cout=%b ovf=%b, want 9 77 0 0",
                     e, i8a.sum, i8a.cout, i8a.overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive_w4();
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int s = 0; s < 2; s++) begin
                        int sa, sb, u, r, k;
                        logic [5:0] expv;
                        logic [5:0] got;
                        logic       dn;
                        logic [2:0] seen;
                        sa = (av >= 8) ? av - 16 : av;
                        sb = (bv >= 8) ? bv - 16 : bv;
                        if (s == 0) begin
                            u = av + bv + c;
                            r = sa + sb + c;
                            expv = {u >= 16, (r < -8 || r > 7), 4'(u & 15)};
                        end else begin
                            u = av - bv - c;
                            r = sa - sb - c;
                            expv = {u >= 0, (r < -8 || r > 7), 4'(u & 15)};
                        end
                        @(negedge clk);
                        i4a.a = 4'(av); i4a.b = 4'(bv); i4a.cin = c[0]; i4a.sub = s[0]; i4a.start = 1'b1;
                        i4b.a = 4'(av); i4b.b = 4'(bv); i4b.cin = c[0]; i4b.sub = s[0]; i4b.start = 1'b1;
                        i4c.a = 4'(av); i4c.b = 4'(bv); i4c.cin = c[0]; i4c.sub = s[0]; i4c.start = 1'b1;
                        @(negedge clk);
                        i4a.start = 1'b0; i4b.start = 1'b0; i4c.start = 1'b0;
                        seen = 3'b000;
                        k = 0;
                        while (seen != 3'b111 && k < 8) begin
                            k++;
                            @(negedge clk);
                            for (int d = 0; d < 3; d++) begin
                                case (d)
                                    0:       begin dn = i4a.done; got = {i4a.cout, i4a.overflow, i4a.sum}; end
                                    1:       begin dn = i4b.done; got = {i4b.cout, i4b.overflow, i4b.sum}; end
                                    default: begin dn = i4c.done; got = {i4c.cout, i4c.overflow, i4c.sum}; end
                                endcase
                                if (!seen[d] && dn === 1'b1) begin
                                    seen[d] = 1'b1;
                                    total++;
                                    if (got !== expv) begin
                                        bad++;
                                        $display("FAIL exh_w4_dsel%0d a=%0d b=%0d cin=%0d sub=%0d: cout/ovf/sum=%b/%b/%h, want %b/%b/%h",
                                                 d, av, bv, c, s, got[5], got[4], got[3:0], expv[5], expv[4], expv[3:0]);
                                    end
                                end
                            end
                        end
                        for (int d = 0; d < 3; d++) begin
                            if (!seen[d]) begin
                                total++;
                                bad++;
                                $display("FAIL exh_w4_timeout dsel%0d a=%0d b=%0d cin=%0d sub=%0d: no done", d, av, bv, c, s);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i8a.start = 1'b0; i8a.a = '0; i8a.b = '0; i8a.cin = 1'b0; i8a.sub = 1'b0;
        i8b.start = 1'b0; i8b.a = '0; i8b.b = '0; i8b.cin = 1'b0; i8b.sub = 1'b0;
        i4a.start = 1'b0; i4a.a = '0; i4a.b = '0; i4a.cin = 1'b0; i4a.sub = 1'b0;
        i4b.start = 1'b0; i4b.a = '0; i4b.b = '0; i4b.cin = 1'b0; i4b.sub = 1'b0;
        i4c.start = 1'b0; i4c.a = '0; i4c.b = '0; i4c.cin = 1'b0; i4c.sub = 1'b0;
        test_reset();
        test_digit1_add();
        test_digit2_sub();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive_w4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
